// File: rtl/cpu_controller_pkg.sv
// rtl/cpu_controller_pkg.sv - shared opcode and controller phase typedefs
package cpu_controller_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } ctrl_state_t;

  // The phase the sequencer parks in once an HLT has been decoded.
  localparam logic [2:0] HALT_PHASE = 3'd5;

endpackage

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - controller <-> datapath/memory strobe bundle
interface cpu_controller_if;
  import cpu_controller_pkg::*;

  opcode_t     opcode;
  logic        zero;
  logic        mem_rd;
  logic        mem_wr;
  logic        load_ir;
  logic        load_ac;
  logic        inc_pc;
  logic        load_pc;
  logic        halt;
  ctrl_state_t phase;

  // master: the controller; slave: instruction register, ALU and memory side
  modport master (
    input  opcode, zero,
    output mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, phase
  );

endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-phase fetch/execute sequencer for the accumulator CPU
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cpu_controller_if.master   bus
);

  ctrl_state_t phase_q, phase_d;
  logic        halted_q, halted_d;

  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

  always_comb begin
    halted_d = halted_q | ((phase_q == OP_ADDR) && (bus.opcode == HLT));
    phase_d  = halted_q ? phase_q : ctrl_state_t'(phase_q + 3'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Once halted every strobe is held low; only halt and phase stay live.
  always_comb begin
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.load_ir = 1'b0;
    bus.load_ac = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.load_pc = 1'b0;
    bus.halt    = halted_q;
    bus.phase   = phase_q;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: ;
        INST_FETCH: bus.mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          bus.mem_rd  = 1'b1;
          bus.load_ir = 1'b1;
        end
        OP_ADDR: bus.inc_pc = 1'b1;
        OP_FETCH: bus.mem_rd = is_aluop(bus.opcode);
        ALU_OP: begin
          bus.mem_rd  = is_aluop(bus.opcode);
          bus.load_ac = is_aluop(bus.opcode);
          bus.inc_pc  = (bus.opcode == SKZ) && bus.zero;
          bus.load_pc = (bus.opcode == JMP);
        end
        STORE: begin
          bus.mem_rd  = is_aluop(bus.opcode);
          bus.load_ac = is_aluop(bus.opcode);
          bus.load_pc = (bus.opcode == JMP);
          bus.mem_wr  = (bus.opcode == STO);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller
module tb_cpu_controller;
  import cpu_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: instruction step count 0..7 and a halted flag.
  int m_phase  = 0;
  bit m_halted = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: observed %03h expected %03h", tag, $time, obs, exp);
    end
  endtask

  // {halt, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, phase[2:0]}
  function automatic logic [31:0] dut_outputs();
    return {22'd0, bus.halt, bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac,
            bus.inc_pc, bus.load_pc, 3'(bus.phase)};
  endfunction

  function automatic logic [31:0] model_outputs(input int ph, input bit h,
                                                input opcode_t op, input bit z);
    bit alu, rd, wr, ir, ac, inc, lpc;
    if (h) return {22'd0, 1'b1, 6'd0, 3'd5};
    alu = op inside {ADD, AND, XOR, LDA};
    rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    ir  = (ph == 2 || ph == 3);
    ac  = (ph == 6 || ph == 7) && alu;
    inc = (ph == 4) || (ph == 6 && op == SKZ && z);
    lpc = (ph == 6 || ph == 7) && op == JMP;
    wr  = (ph == 7) && op == STO;
    return {22'd0, 1'b0, rd, wr, ir, ac, inc, lpc, 3'(ph)};
  endfunction

  // Called at posedge+1: drive inputs, check mid-cycle, then clock the model.
  task automatic cycle(input string tag, input opcode_t op, input bit z);
    bus.opcode = op;
    bus.zero   = z;
    #1;
    check(tag, dut_outputs(), model_outputs(m_phase, m_halted, op, z));
    @(posedge clk);
    if (!m_halted) begin
      if (m_phase == 4 && op == HLT) m_halted = 1'b1;
      m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check(tag, dut_outputs(), 32'd0);
    m_phase  = 0;
    m_halted = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_held"}, dut_outputs(), 32'd0);
    rst = 1'b0;
  endtask

  task automatic run_instr(input string tag, input opcode_t op, input bit z);
    for (int i = 0; i < 8; i++) cycle(tag, op, z);
  endtask

  initial begin
    bus.opcode = ADD;
    bus.zero   = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    run_instr("add", ADD, 1'b0);
    run_instr("sto", STO, 1'b1);
    run_instr("skz_z1", SKZ, 1'b1);
    run_instr("skz_z0", SKZ, 1'b0);
    run_instr("jmp", JMP, 1'b0);
    run_instr("lda", LDA, 1'b1);
    check("wrap_to_0", 32'(bus.phase), 32'd0);

    // Reset in phase 6 of an ADD: outputs clear with no clock edge.
    for (int i = 0; i < 6; i++) cycle("add_pre_rst", ADD, 1'b0);
    check("at_phase6", 32'(bus.phase), 32'd6);
    do_reset("rst_mid_add");
    run_instr("after_rst", XOR, 1'b0);

    // HLT, then 20 cycles of every opcode while parked.
    for (int i = 0; i < 5; i++) cycle("hlt", HLT, 1'b0);
    check("halt_set", 32'(bus.halt), 32'd1);
    for (int i = 0; i < 20; i++) cycle("halted", opcode_t'(3'(i % 8)), (i % 3) == 0);
    do_reset("rst_halted");
    run_instr("after_halt_rst", AND, 1'b1);

    // Random opcode/zero every cycle, with resets to escape halt or at random.
    for (int i = 0; i < 600; i++) begin
      if ((m_halted && $urandom_range(3, 0) == 0) || $urandom_range(79, 0) == 0)
        do_reset("rand_rst");
      else
        cycle("rand", opcode_t'(3'($urandom_range(7, 0))), 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-sequencing controller for the 8-opcode accumulator CPU. It consumes the 3-bit `opcode_t` held in the instruction register and the accumulator zero flag. It steps a fixed 8-phase fetch/execute cycle and drives the memory, program-counter, instruction-register and accumulator strobes. It sits between the instruction register/ALU datapath and the shared memory, and is the decoding end of the opcode encoding defined in the shared typedefs package.

## Interface
- No parameters; opcode width (3) and phase count (8) are fixed by the package types.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  3 (`opcode_t`)  current instruction register contents.
- `zero`  in  1  accumulator-equals-zero flag from ALU.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `load_ir`  out  1  load instruction register from memory data.
- `load_ac`  out  1  load accumulator from ALU result.
- `inc_pc`  out  1  increment program counter.
- `load_pc`  out  1  load program counter from instruction operand field.
- `halt`  out  1  CPU halted; sticky until reset.
- `phase`  out  3  current phase (`ctrl_state_t` encoding), for debug/verification.

## Operation
- Phase register cycles INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7) → INST_ADDR, one phase per clock, wrap 7→0.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Strobes are decoded combinationally from phase, opcode and zero. Every strobe is 0 in any phase not listed below.
- INST_FETCH: mem_rd=1.
- INST_LOAD, IDLE: mem_rd=1, load_ir=1.
- OP_ADDR: inc_pc=1. If opcode==HLT, the halted flag is set at the clock edge ending this phase.
- OP_FETCH: mem_rd=ALUOP.
- ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
- STORE: mem_rd=ALUOP, load_ac=ALUOP, load_pc=(opcode==JMP), mem_wr=(opcode==STO).
- Halted state:
  - The phase register freezes at OP_FETCH (5) and halt=1.
  - All other strobes are forced to 0 regardless of opcode or zero.
  - Only rst exits the halted state.
- opcode and zero are don't-care in phases 0–3. Changes to them there have no effect on outputs.
- Opcode values outside the enum cannot occur, since the 3-bit encoding is fully used.

## Timing
- Reset (async assert, synchronous deassert handled upstream): phase=INST_ADDR, halted=0, so all outputs are 0 immediately on rst assertion.
- First clock edge after rst drops moves phase to INST_FETCH.
- Full instruction latency: exactly 8 clocks. No stalls, no handshakes.
- Strobe outputs change only as a consequence of a phase change or an opcode/zero change within the same phase. They must be glitch-tolerant for the synchronous datapath (sampled at the next edge).
- halt rises on the edge ending OP_ADDR of an HLT instruction. The inc_pc pulse in that OP_ADDR still occurs.
- Reset asserted mid-instruction (any phase, halted or not) immediately returns phase to 0 and all outputs to 0. The partial instruction is discarded.
- Simultaneous SKZ with zero=1 in ALU_OP: inc_pc=1 for exactly one cycle, giving a net PC+2 over the instruction.

## Structure
- Shared package (existing typedefs package) holds `opcode_t` and the new `ctrl_state_t` enum (8 phase names, 3-bit encoding 0–7).
- Single module, no sub-modules. It contains:
  - one sequential process (phase register plus halted flag),
  - one combinational decode process using `unique case` on phase.
- The ALUOP membership test is a local function.

## Test plan
- Reset then opcode=ADD, zero=0, 8 clocks → load_ir=1 in phases 2–3; mem_rd=1 in phases 1–3 and 5–7; load_ac=1 in phases 6–7; inc_pc=1 only in phase 4; phase returns to 0.
- opcode=STO for 8 clocks → mem_wr=1 only in phase 7; load_ac and mem_rd=0 in phases 5–7.
- opcode=SKZ: zero=1 gives inc_pc=1 in phases 4 and 6; zero=0 gives inc_pc=1 in phase 4 only.
- opcode=JMP → load_pc=1 in phases 6–7 and inc_pc=1 in phase 4 only; no mem_rd in phases 5–7.
- opcode=HLT → halt=1 from the edge ending phase 4. Run 20 more clocks with opcode cycling through all values: phase stays 5, all strobes stay 0.
- Assert rst in phase 6 of an ADD, and again while halted → all outputs 0 immediately without a clock edge. After release, the 8-phase sequence restarts from phase 0.
